// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin arbiter that drains NUM_SRC FIFOs into one registered output stream,
// holding each grant for up to BURST consecutive items.
module fifo_rr_drain_arbiter #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned IDX_WIDTH  = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST      = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_SRC-1:0]            i_empty,
    output logic [NUM_SRC-1:0]            o_deq,
    output logic [DATA_WIDTH-1:0]         o_item,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [IDX_WIDTH-1:0]          o_grant,
    output logic                          o_busy
);

    localparam int unsigned CntWidth = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_WIDTH-1:0]  grant_q, grant_d;
    logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CntWidth-1:0]   burst_cnt_q, burst_cnt_d;
    logic [DATA_WIDTH-1:0] item_q, item_d;
    logic                  valid_q, valid_d;

    logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
    logic [NUM_SRC-1:0]    deq;
    logic                  slot_free;
    logic                  pick_found;
    logic [IDX_WIDTH-1:0]  pick_idx;
    logic [IDX_WIDTH-1:0]  cand;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
        assign src_data[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign slot_free = ~valid_q | i_ready;

    // First non-empty source strictly after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned off = 1; off <= NUM_SRC; off++) begin
            cand = IDX_WIDTH'((32'(rr_ptr_q) + off) % NUM_SRC);
            if (!pick_found && !i_empty[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        item_d      = item_q;
        valid_d     = valid_q;
        deq         = '0;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = StGrant;
                end
            end
            StGrant: begin
                if (i_empty[grant_q]) begin
                    // Early release: source ran dry before the burst completed.
                    state_d  = StIdle;
                    rr_ptr_d = grant_q;
                end else if (slot_free) begin
                    deq[grant_q] = 1'b1;
                    item_d       = src_data[grant_q];
                    valid_d      = 1'b1;
                    burst_cnt_d  = burst_cnt_q + CntWidth'(1);
                    if (burst_cnt_q == CntWidth'(BURST - 1)) begin
                        state_d  = StIdle;
                        rr_ptr_d = grant_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= IDX_WIDTH'(NUM_SRC - 1);
            burst_cnt_q <= '0;
            item_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            item_q      <= item_d;
            valid_q     <= valid_d;
        end
    end

    // Gate strobes with reset so nothing pops while reset is asserted.
    assign o_deq   = deq & {NUM_SRC{i_rst_n}};
    assign o_item  = item_q;
    assign o_valid = valid_q;
    assign o_grant = grant_q;
    assign o_busy  = (state_q == StGrant);

endmodule

// File: doc/fifo_rr_drain_arbiter.md
Name: fifo_rr_drain_arbiter

Overview:
- Round-robin arbiter that drains NUM_SRC upstream FIFOs into one registered output stream. It sits between the bank of per-lane FIFOs and a single downstream consumer, such as a merger stage or a shared FIFO.
- Uses each FIFO's combinational head data and empty flag. Issues one-hot dequeue strobes.
- Holds a grant for up to BURST items so the consumer sees contiguous runs from one source.

Parameters:
- NUM_SRC, 4, number of requesting FIFOs (2..16).
- IDX_WIDTH, 2, width of source index; must equal ceil(log2(NUM_SRC)), minimum 1.
- DATA_WIDTH, 32, item width.
- BURST, 4, maximum consecutive items taken from one source per grant (1..16).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_data  in  NUM_SRC*DATA_WIDTH  head items, flattened; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_empty  in  NUM_SRC  per-source empty flags.
- o_deq  out  NUM_SRC  one-hot dequeue strobes (combinational from state and inputs).
- o_item  out  DATA_WIDTH  registered output item.
- o_valid  out  1  o_item holds a valid item.
- i_ready  in  1  downstream accepts o_item this cycle when o_valid=1.
- o_grant  out  IDX_WIDTH  currently granted source index.
- o_busy  out  1  FSM in GRANT.

Behaviour:
- Reset (i_rst_n=0, asynchronous): state=IDLE, o_item=0, o_valid=0, o_grant=0, burst_cnt=0, rr_ptr=NUM_SRC-1, o_busy=0. o_deq=0 while reset is asserted.
- Mid-operation reset discards any item held in o_item. No dequeue strobe may be asserted during reset.
- slot_free = ~o_valid | i_ready.
- IDLE state:
  - If any i_empty bit is 0, pick the first non-empty source searching from rr_ptr+1 upward, modulo NUM_SRC.
  - On the next edge: o_grant<=that index, burst_cnt<=0, state<=GRANT.
  - If all sources are empty, stay in IDLE.
  - o_deq=0 in IDLE, so a source switch costs exactly one bubble cycle.
- GRANT state, with g=o_grant:
  - o_deq[g]=1 iff ~i_empty[g] & slot_free. All other o_deq bits are 0.
  - On a deq edge: o_item<=i_data[g], o_valid<=1, burst_cnt<=burst_cnt+1.
  - If burst_cnt==BURST-1 at that edge: state<=IDLE, rr_ptr<=g.
  - If i_empty[g]=1 in GRANT: no deq; state<=IDLE, rr_ptr<=g on that edge. This is an early release; burst_cnt is discarded.
  - If ~slot_free and i_empty[g]=0: hold state, o_item and o_valid. Stall, no release.
- Output register, when no deq this cycle: if o_valid & i_ready then o_valid<=0. o_item keeps its last value.
- Simultaneous i_ready and deq: old item is consumed and the new item is loaded on the same edge. o_valid stays 1, giving full throughput of 1 item/cycle within a burst.
- Latency: an item dequeued at edge N appears on o_item/o_valid after edge N.
- First grant after reset goes to source 0 if it is non-empty.
- o_busy = (state==GRANT).
- burst_cnt is wide enough for BURST-1. The compare is exact, so there is no wrap inside a grant.
- The arbiter never dequeues an empty source and never overwrites an unconsumed valid item. These are assertion targets for verification.

Test Plan:
1. Reset; source 0 holds 6 items (0xA0..0xA5), i_ready=1 -> o_deq[0] pulses 4 cycles, o_item streams A0..A3, then 1 bubble, then re-grant to 0 and streams A4,A5, then release on empty.
2. All 4 sources non-empty with 8 items each, BURST=4, i_ready=1 -> grant order 0,1,2,3,0,1,2,3. Each run is 4 items, with one bubble between runs. 32 items total, none lost or duplicated.
3. Source 2 only, i_ready held 0 for 5 cycles after the first item -> o_valid=1 and o_item stable; o_deq=0 throughout the stall; resumes at 1 item/cycle when i_ready=1.
4. Source 1 holds 2 items, source 3 holds 4 -> grant 1 releases early after 2 items; next grant is 3 and all 4 items from source 3 are delivered; rr_ptr=3, so the next search starts at 0.
5. Assert i_rst_n=0 mid-burst with o_valid=1 -> o_valid, o_deq and o_busy go to 0 immediately (no clock needed). After release, arbitration restarts at source 0.
6. Random i_empty/i_ready for 10k cycles against a scoreboard model -> per-source order is preserved; no deq while empty; no deq while ~slot_free; o_deq is always one-hot or zero.
